// File: rtl/mem_bus_if_if.sv
// Bus-side signal bundle between one CPU's bus master and the shared
// grant-controlled address/data/rw_ multiplexer in front of the devices.
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mem_bus_if_if #(
  parameter int unsigned ADDR_W = `BUS_ADDR_WIDTH,
  parameter int unsigned DATA_W = `DATA_WIDTH
);
  logic              breq_;
  logic              bgrt_;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rw_;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output breq_,
    output bus_addr,
    output bus_wdata,
    output bus_rw_,
    input  bgrt_,
    input  bus_rdata
  );

  modport slave (
    input  breq_,
    input  bus_addr,
    input  bus_wdata,
    input  bus_rw_,
    output bgrt_,
    output bus_rdata
  );
endinterface

// File: rtl/mem_bus_if.sv
// Per-CPU bus master: turns the core's level memread/memwrite into an
// active-low bus request, performs one transfer under grant and stalls the core.
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_bus_if #(
  parameter int unsigned ADDR_W = `BUS_ADDR_WIDTH,
  parameter int unsigned DATA_W = `DATA_WIDTH,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              bus_err,
  mem_bus_if_if.master      bus
);

  localparam logic [3:0] LastCnt = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cpu_req;
  logic              in_xfer;

  assign cpu_req = cpu_memread | cpu_memwrite;
  assign in_xfer = (state_q == StXfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          rd_d    = cpu_memread;  // read wins when both lines are high
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!bus.bgrt_) begin
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Losing the grant is only flagged; the transfer still runs to completion.
        if (bus.bgrt_) begin
          err_d = 1'b1;
        end
        if (!rd_q) begin
          state_d = StRelease;
        end else if (cnt_q == LastCnt) begin
          rdata_d = bus.bus_rdata;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRelease: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.breq_     = !((state_q == StReq) || in_xfer);
  assign bus.bus_addr  = in_xfer ? addr_q : '0;
  assign bus.bus_rw_   = in_xfer ? rd_q : 1'b1;
  assign bus.bus_wdata = (in_xfer && !rd_q) ? wdata_q : '0;

  assign cpu_done  = (state_q == StRelease);
  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;
  assign cpu_stall = (state_q == StReq) || in_xfer || ((state_q == StIdle) && cpu_req);

endmodule
